sub_operand_seq: RTL and testbench

Sequencer that sits around the 8-bit ripple subtractor in the ULA.
- Upstream: accepts operand A, then operand B, as bytes from a valid/ready byte stream.
- Drives both operands and the output-buffer enable into the subtractor.
- Downstream: captures the 9-bit result (difference plus borrow) into a register and presents it with flags on a valid/ready output interface.
- Counts completed operations.

---
 rtl/sub_operand_seq_if.sv | 30 +++
 rtl/sub_operand_seq.sv | 112 +++++++++++
 tb/tb_sub_operand_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sub_operand_seq_if.sv
// Byte-stream input, subtractor drive/return and result output of the subtract sequencer.
// The slave modport is the sequencer side; the master modport is the surrounding environment.
interface sub_operand_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sub_a;
    logic [WIDTH-1:0] sub_b;
    logic             sub_en;
    logic [WIDTH:0]   sub_t;
    logic [WIDTH:0]   out_res;
    logic             out_zero;
    logic             out_borrow;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] op_cnt;

    modport slave (
        input  in_data, in_valid, sub_t, out_ready,
        output in_ready, sub_a, sub_b, sub_en, out_res, out_zero, out_borrow, out_valid, op_cnt
    );

    modport master (
        output in_data, in_valid, sub_t, out_ready,
        input  in_ready, sub_a, sub_b, sub_en, out_res, out_zero, out_borrow, out_valid, op_cnt
    );
endinterface

// File: rtl/sub_operand_seq.sv
// Loads A then B, pulses the subtractor enable for one cycle and holds the captured result.
// Result valid one cycle after the EXEC edge; stalls in DONE (in_ready=0) until out_ready.
module sub_operand_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sub_operand_seq_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sub_a_q, sub_a_d;
    logic [WIDTH-1:0] sub_b_q, sub_b_d;
    logic [WIDTH:0]   out_res_q, out_res_d;
    logic             out_zero_q, out_zero_d;
    logic             out_borrow_q, out_borrow_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

    logic in_ready;
    logic sub_en;
    logic out_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sub_a_q      <= '0;
            sub_b_q      <= '0;
            out_res_q    <= '0;
            out_zero_q   <= 1'b0;
            out_borrow_q <= 1'b0;
            op_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            sub_a_q      <= sub_a_d;
            sub_b_q      <= sub_b_d;
            out_res_q    <= out_res_d;
            out_zero_q   <= out_zero_d;
            out_borrow_q <= out_borrow_d;
            op_cnt_q     <= op_cnt_d;
        end
    end

    // sub_t is only trusted while the enable is up, so it is sampled in EXEC alone.
    always_comb begin
        state_d      = state_q;
        sub_a_d      = sub_a_q;
        sub_b_d      = sub_b_q;
        out_res_d    = out_res_q;
        out_zero_d   = out_zero_q;
        out_borrow_d = out_borrow_q;
        op_cnt_d     = op_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sub_a_d = bus.in_data;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (bus.in_valid) begin
                    sub_b_d = bus.in_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                out_res_d    = bus.sub_t;
                out_zero_d   = (bus.sub_t[WIDTH-1:0] == '0);
                out_borrow_d = bus.sub_t[WIDTH];
                state_d      = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    op_cnt_d = op_cnt_q + CNT_W'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        sub_en    = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            LOAD_B:  in_ready  = 1'b1;
            EXEC:    sub_en    = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.in_ready   = in_ready;
    assign bus.sub_en     = sub_en;
    assign bus.out_valid  = out_valid;
    assign bus.sub_a      = sub_a_q;
    assign bus.sub_b      = sub_b_q;
    assign bus.out_res    = out_res_q;
    assign bus.out_zero   = out_zero_q;
    assign bus.out_borrow = out_borrow_q;
    assign bus.op_cnt     = op_cnt_q;

endmodule

// File: tb/tb_sub_operand_seq.sv
// Directed bench for sub_operand_seq; a behavioural subtractor returns {borrow, diff} while
// sub_en is high and a junk pattern otherwise, so out-of-window sampling shows up.
module tb_sub_operand_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sub_operand_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    sub_operand_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.sub_t = bus.sub_en ? ({1'b0, bus.sub_a} - {1'b0, bus.sub_b}) : 9'h1A5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 8'hAA;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.op_cnt !== 8'h00) begin bad++; $display("FAIL reset_op_cnt got=%h want=00", bus.op_cnt); end
        total++; if (bus.sub_en !== 1'b0) begin bad++; $display("FAIL reset_sub_en got=%b want=0", bus.sub_en); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        total++; if (bus.sub_a !== 8'h00) begin bad++; $display("FAIL reset_sub_a got=%h want=00", bus.sub_a); end
        total++; if (bus.out_res !== 9'h000 || bus.out_zero !== 1'b0 || bus.out_borrow !== 1'b0) begin
            bad++; $display("FAIL reset_result got=%h/%b/%b want=000/0/0", bus.out_res, bus.out_zero, bus.out_borrow);
        end
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        total++; if (bus.sub_a !== 8'h00 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_idle_hold sub_a=%h in_ready=%b want=00/1", bus.sub_a, bus.in_ready);
        end
    endtask

    task automatic test_basic();
        int en_cycles;
        en_cycles = 0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h05;
        @(negedge clk);
        if (bus.sub_en) en_cycles++;
        total++; if (bus.in_ready !== 1'b1 || bus.sub_a !== 8'h05) begin
            bad++; $display("FAIL basic_load_a in_ready=%b sub_a=%h want=1/05", bus.in_ready, bus.sub_a);
        end
        bus.in_data = 8'h03;
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (bus.sub_en) en_cycles++;
        total++; if (bus.sub_en !== 1'b1 || bus.in_ready !== 1'b0 || bus.sub_b !== 8'h03) begin
            bad++; $display("FAIL basic_exec sub_en=%b in_ready=%b sub_b=%h want=1/0/03", bus.sub_en, bus.in_ready, bus.sub_b);
        end
        @(negedge clk);
        if (bus.sub_en) en_cycles++;
        total++; if (bus.out_valid !== 1'b1 || bus.out_res !== 9'h002 || bus.out_zero !== 1'b0 || bus.out_borrow !== 1'b0) begin
            bad++; $display("FAIL basic_result got=%b/%h/%b/%b want=1/002/0/0", bus.out_valid, bus.out_res, bus.out_zero, bus.out_borrow);
        end
        @(negedge clk);
        if (bus.sub_en) en_cycles++;
        total++; if (bus.out_valid !== 1'b0 || bus.op_cnt !== 8'd1 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL basic_done out_valid=%b op_cnt=%0d in_ready=%b want=0/1/1", bus.out_valid, bus.op_cnt, bus.in_ready);
        end
        total++; if (en_cycles != 1) begin bad++; $display("FAIL basic_sub_en_cycles got=%0d want=1", en_cycles); end
    endtask

    task automatic test_borrow();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h03;
        @(negedge clk);
        bus.in_data = 8'h05;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        total++; if (bus.out_res !== 9'h1FE || bus.out_borrow !== 1'b1 || bus.out_zero !== 1'b0) begin
            bad++; $display("FAIL borrow_result got=%h/%b/%b want=1fe/1/0", bus.out_res, bus.out_borrow, bus.out_zero);
        end
        @(negedge clk);
        total++; if (bus.op_cnt !== 8'd2) begin bad++; $display("FAIL borrow_op_cnt got=%0d want=2", bus.op_cnt); end
    endtask

    task automatic test_zero_stall();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h80;
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.out_valid !== 1'b1 || bus.out_res !== 9'h000 || bus.out_zero !== 1'b1 || bus.in_ready !== 1'b0) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%b/%b want=1/000/1/0", i, bus.out_valid, bus.out_res, bus.out_zero, bus.in_ready);
            end
            bus.in_valid = (i % 2 == 0);
            bus.in_data = 8'h77;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1 || bus.op_cnt !== 8'd2) begin
            bad++; $display("FAIL stall_before_hs out_valid=%b op_cnt=%0d want=1/2", bus.out_valid, bus.op_cnt);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0 || bus.op_cnt !== 8'd3 || bus.sub_a !== 8'h80 || bus.sub_b !== 8'h80) begin
            bad++; $display("FAIL stall_hs out_valid=%b op_cnt=%0d sub_a=%h sub_b=%h want=0/3/80/80", bus.out_valid, bus.op_cnt, bus.sub_a, bus.sub_b);
        end
        @(negedge clk);
        total++; if (bus.op_cnt !== 8'd3) begin bad++; $display("FAIL stall_once op_cnt=%0d want=3", bus.op_cnt); end
    endtask

    task automatic test_gap_reset();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h10;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (bus.in_ready !== 1'b1 || bus.sub_en !== 1'b0 || bus.out_valid !== 1'b0 || bus.sub_a !== 8'h10) begin
                bad++; $display("FAIL gap_hold cyc=%0d in_ready=%b sub_en=%b out_valid=%b sub_a=%h want=1/0/0/10", i, bus.in_ready, bus.sub_en, bus.out_valid, bus.sub_a);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (bus.sub_a !== 8'h00 || bus.op_cnt !== 8'd0) begin
            bad++; $display("FAIL gap_reset sub_a=%h op_cnt=%0d want=00/0", bus.sub_a, bus.op_cnt);
        end
        bus.in_valid = 1'b1;
        bus.in_data = 8'h22;
        @(negedge clk);
        total++; if (bus.sub_a !== 8'h22 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL gap_new_a sub_a=%h in_ready=%b want=22/1", bus.sub_a, bus.in_ready);
        end
        bus.in_data = 8'h01;
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++; if (bus.sub_en !== 1'b1 || bus.sub_b !== 8'h01) begin
            bad++; $display("FAIL gap_new_b sub_en=%b sub_b=%h want=1/01", bus.sub_en, bus.sub_b);
        end
        @(negedge clk);
        total++; if (bus.out_res !== 9'h021 || bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL gap_result got=%h/%b want=021/1", bus.out_res, bus.out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [7:0] a, b;
        logic [8:0] exp_res;
        logic [7:0] fixed_a [4];
        logic [7:0] fixed_b [4];
        fixed_a = '{8'h00, 8'hFF, 8'h7F, 8'h01};
        fixed_b = '{8'hFF, 8'h00, 8'h80, 8'h01};
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 256; n++) begin
            if (n < 4) begin
                a = fixed_a[n];
                b = fixed_b[n];
            end else begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
            end
            exp_res[7:0] = 8'(a - b);
            exp_res[8]   = (a < b);
            bus.in_valid = 1'b1;
            bus.in_data = a;
            @(negedge clk);
            bus.in_data = b;
            @(negedge clk);
            bus.in_valid = 1'b0;
            @(negedge clk);
            total++; if (bus.out_valid !== 1'b1 || bus.out_res !== exp_res || bus.out_borrow !== exp_res[8] ||
                         bus.out_zero !== (exp_res[7:0] == 8'h00)) begin
                bad++; $display("FAIL wrap_result n=%0d a=%h b=%h got=%h/%b/%b want=%h/%b/%b", n, a, b,
                                bus.out_res, bus.out_borrow, bus.out_zero, exp_res, exp_res[8], (exp_res[7:0] == 8'h00));
            end
            @(negedge clk);
            if (n == 254) begin
                total++; if (bus.op_cnt !== 8'hFF) begin bad++; $display("FAIL wrap_max op_cnt=%h want=ff", bus.op_cnt); end
            end
        end
        total++; if (bus.op_cnt !== 8'h00) begin bad++; $display("FAIL wrap_zero op_cnt=%h want=00", bus.op_cnt); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
        test_zero_stall();
        test_gap_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
